// File: rtl/bb_frontier_sched.sv
// Thread-frontier scheduler: forwards CVU updates to the mask file (1 cycle) and issues the lowest pending row,
// 3 cycles from pending to issue_valid; issue holds stable under backpressure while updates keep being accepted.
module bb_frontier_sched #(
  parameter int BBS = 32,
  parameter int W   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd_valid,
  input  logic [4:0]   upd_bb,
  input  logic [W-1:0] upd_mask,
  output logic         rf_write_en,
  output logic [4:0]   rf_write_reg,
  output logic [W-1:0] rf_write_data,
  output logic         rf_read_en,
  output logic [4:0]   rf_read_reg,
  input  logic [W-1:0] rf_read_data,
  output logic         issue_valid,
  input  logic         issue_ready,
  output logic [4:0]   issue_bb,
  output logic [W-1:0] issue_mask,
  output logic         done
);

  typedef enum logic [1:0] {SELECT, READ, WAIT, ISSUE} state_t;

  localparam logic [BBS-1:0] ONE = {{(BBS-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic           r_wr_valid;
  logic [4:0]     r_wr_bb;
  logic [W-1:0]   r_wr_mask;
  logic [BBS-1:0] r_pending;
  logic [4:0]     r_sel_bb;
  logic [4:0]     r_issue_bb;
  logic [W-1:0]   r_issue_mask;

  logic           w_conflict;
  logic           w_read_en;
  logic [4:0]     w_lowest;
  logic [BBS-1:0] w_set;
  logic [BBS-1:0] w_clr;

  always_comb begin
    w_lowest = '0;
    for (int i = BBS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowest = 5'(i);
    end
  end

  // Stalling the read while the same row is being OR-written keeps those threads from being cleared unseen.
  assign w_conflict = r_wr_valid && (r_wr_bb == r_sel_bb);
  assign w_read_en  = (r_state == READ) && !w_conflict;
  assign w_set      = r_wr_valid ? (ONE << r_wr_bb) : '0;
  assign w_clr      = w_read_en ? (ONE << r_sel_bb) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_valid <= 1'b0;
      r_wr_bb    <= '0;
      r_wr_mask  <= '0;
    end else begin
      r_wr_valid <= upd_valid && (upd_mask != '0);
      r_wr_bb    <= upd_bb;
      r_wr_mask  <= upd_mask;
    end
  end

  // Row 0 comes out of reset holding all threads, so its pending bit starts set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= ONE;
    else      r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= SELECT;
      r_sel_bb     <= '0;
      r_issue_bb   <= '0;
      r_issue_mask <= '0;
    end else begin
      case (r_state)
        SELECT: begin
          if (r_pending != '0) begin
            r_sel_bb <= w_lowest;
            r_state  <= READ;
          end
        end
        READ: begin
          if (w_read_en) r_state <= WAIT;
        end
        WAIT: begin
          r_issue_mask <= rf_read_data;
          r_issue_bb   <= r_sel_bb;
          r_state      <= ISSUE;
        end
        ISSUE: begin
          if (issue_ready) r_state <= SELECT;
        end
        default: r_state <= SELECT;
      endcase
    end
  end

  assign rf_write_en   = r_wr_valid;
  assign rf_write_reg  = r_wr_bb;
  assign rf_write_data = r_wr_mask;
  assign rf_read_en    = w_read_en;
  assign rf_read_reg   = r_sel_bb;
  assign issue_valid   = (r_state == ISSUE);
  assign issue_bb      = r_issue_bb;
  assign issue_mask    = r_issue_mask;
  assign done          = (r_state == SELECT) && (r_pending == '0) && !r_wr_valid;

endmodule

// File: tb/tb_bb_frontier_sched.sv
// Bench for bb_frontier_sched: behavioural mask file, directed scenarios and a randomized
// run checked against a per-block thread-conservation model.
module tb_bb_frontier_sched;
  localparam int W   = 64;
  localparam int BBS = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         upd_valid = 1'b0;
  logic [4:0]   upd_bb = '0;
  logic [W-1:0] upd_mask = '0;
  logic         rf_write_en;
  logic [4:0]   rf_write_reg;
  logic [W-1:0] rf_write_data;
  logic         rf_read_en;
  logic [4:0]   rf_read_reg;
  logic [W-1:0] rf_read_data;
  logic         issue_valid;
  logic         issue_ready = 1'b0;
  logic [4:0]   issue_bb;
  logic [W-1:0] issue_mask;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] all1;

  logic [W-1:0] rf_mem [BBS];

  always #5 clk = ~clk;

  bb_frontier_sched #(.BBS(BBS), .W(W)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_bb(upd_bb), .upd_mask(upd_mask),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_bb(issue_bb),
    .issue_mask(issue_mask), .done(done)
  );

  // Mask file: OR-write, read-and-clear, registered read data; a same-row collision loses the write.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BBS; i++) rf_mem[i] <= '0;
      rf_mem[0]    <= '1;
      rf_read_data <= '0;
    end else begin
      if (rf_read_en) rf_read_data <= rf_mem[rf_read_reg];
      if (rf_read_en && rf_write_en && rf_read_reg == rf_write_reg) begin
        rf_mem[rf_read_reg] <= '0;
      end else begin
        if (rf_write_en) rf_mem[rf_write_reg] <= rf_mem[rf_write_reg] | rf_write_data;
        if (rf_read_en)  rf_mem[rf_read_reg]  <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rf_read_en && rf_write_en) begin
      n_tests++;
      if (rf_read_reg == rf_write_reg) begin
        n_fail++;
        $display("FAIL rf_conflict: read and write both hit row %0d", rf_read_reg);
      end
    end
  end

  task automatic send(input logic [4:0] bb, input logic [W-1:0] m);
    upd_valid = 1'b1;
    upd_bb    = bb;
    upd_mask  = m;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Returns at the first negedge after the block has transferred.
  task automatic get_issue(output logic [4:0] bb, output logic [W-1:0] m, output bit ok);
    ok = 1'b0;
    bb = '0;
    m  = '0;
    issue_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (issue_valid) begin
        bb = issue_bb;
        m  = issue_mask;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; issue_ready = 1'b1; upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({issue_valid, rf_read_en, rf_write_en, done} !== 4'b0 || issue_bb !== 5'd0 || issue_mask !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b re=%b we=%b done=%b bb=%0d mask=%h, all required 0",
               issue_valid, rf_read_en, rf_write_en, done, issue_bb, issue_mask);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_issue: issue_valid=%b before edge 3, required 0", issue_valid);
    end
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || issue_bb !== 5'd0 || issue_mask !== all1) begin
      n_fail++;
      $display("FAIL first_issue: v=%b bb=%0d mask=%h, required 1/0/%h", issue_valid, issue_bb, issue_mask, all1);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (issue_valid !== 1'b0 || done !== 1'b1) begin
        n_fail++; $display("FAIL idle_after_first: v=%b done=%b, required 0/1", issue_valid, done);
      end
    end
  endtask

  task automatic test_order();
    logic [4:0] gb; logic [W-1:0] gm; bit ok;
    rst = 1'b0; issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(5'd5, 64'hF);
    send(5'd2, 64'hF0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || issue_bb !== 5'd0 || issue_mask !== all1) begin
      n_fail++; $display("FAIL order_hold0: v=%b bb=%0d mask=%h, required 1/0/all-ones", issue_valid, issue_bb, issue_mask);
    end
    get_issue(gb, gm, ok);
    n_tests++;
    if (!ok || gb !== 5'd0 || gm !== all1) begin
      n_fail++; $display("FAIL order_0: ok=%0d bb=%0d mask=%h, required bb=0 all-ones", ok, gb, gm);
    end
    get_issue(gb, gm, ok);
    n_tests++;
    if (!ok || gb !== 5'd2 || gm !== 64'hF0) begin
      n_fail++; $display("FAIL order_2: ok=%0d bb=%0d mask=%h, required bb=2 mask=f0", ok, gb, gm);
    end
    get_issue(gb, gm, ok);
    n_tests++;
    if (!ok || gb !== 5'd5 || gm !== 64'hF) begin
      n_fail++; $display("FAIL order_5: ok=%0d bb=%0d mask=%h, required bb=5 mask=f", ok, gb, gm);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL order_done: done=%b v=%b, required 1/0", done, issue_valid);
    end
  endtask

  task automatic test_merge();
    logic [4:0] gb; logic [W-1:0] gm; bit ok;
    send(5'd3, 64'h1);
    send(5'd3, 64'h2);
    get_issue(gb, gm, ok);
    n_tests++;
    if (!ok || gb !== 5'd3 || gm !== 64'h3) begin
      n_fail++; $display("FAIL merge: ok=%0d bb=%0d mask=%h, required bb=3 mask=3", ok, gb, gm);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (issue_valid !== 1'b0) begin
        n_fail++; $display("FAIL merge_single: issue_valid=%b bb=%0d after merged issue, required 0", issue_valid, issue_bb);
      end
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL merge_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_conflict();
    logic [4:0] gb; logic [W-1:0] gm; bit ok;
    send(5'd7, 64'h80);
    @(negedge clk);
    send(5'd7, 64'h100);
    n_tests++;
    if (rf_read_en !== 1'b0 || rf_read_reg !== 5'd7 || rf_write_en !== 1'b1 || rf_write_reg !== 5'd7) begin
      n_fail++;
      $display("FAIL conflict_stall: re=%b rreg=%0d we=%b wreg=%0d, required 0/7/1/7",
               rf_read_en, rf_read_reg, rf_write_en, rf_write_reg);
    end
    @(negedge clk);
    n_tests++;
    if (rf_read_en !== 1'b1 || rf_read_reg !== 5'd7) begin
      n_fail++; $display("FAIL conflict_release: re=%b rreg=%0d, required 1/7", rf_read_en, rf_read_reg);
    end
    get_issue(gb, gm, ok);
    n_tests++;
    if (!ok || gb !== 5'd7 || gm !== 64'h180) begin
      n_fail++; $display("FAIL conflict_mask: ok=%0d bb=%0d mask=%h, required bb=7 mask=180", ok, gb, gm);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] gb; logic [W-1:0] gm; bit ok;
    logic [4:0] exp_bb [3];
    logic [W-1:0] exp_m [3];
    bit seen;
    exp_bb[0] = 5'd9;  exp_m[0] = 64'h5;
    exp_bb[1] = 5'd1;  exp_m[1] = 64'h10;
    exp_bb[2] = 5'd20; exp_m[2] = 64'hAA;
    issue_ready = 1'b0;
    send(5'd9, 64'h5);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = issue_valid;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL bp_reach_issue: issue_valid=0 after 20 cycles, required 1");
    end
    for (int c = 0; c < 10; c++) begin
      upd_valid = (c == 0 || c == 2);
      upd_bb    = (c == 0) ? 5'd1 : 5'd20;
      upd_mask  = (c == 0) ? 64'h10 : 64'hAA;
      @(negedge clk);
      n_tests++;
      if (issue_valid !== 1'b1 || issue_bb !== 5'd9 || issue_mask !== 64'h5) begin
        n_fail++; $display("FAIL bp_stable: v=%b bb=%0d mask=%h, required 1/9/5", issue_valid, issue_bb, issue_mask);
      end
      if (c == 0 || c == 2) begin
        n_tests++;
        if (rf_write_en !== 1'b1 || rf_write_reg !== upd_bb || rf_write_data !== upd_mask) begin
          n_fail++;
          $display("FAIL bp_write: we=%b reg=%0d data=%h, required 1/%0d/%h",
                   rf_write_en, rf_write_reg, rf_write_data, upd_bb, upd_mask);
        end
      end
    end
    upd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      get_issue(gb, gm, ok);
      n_tests++;
      if (!ok || gb !== exp_bb[k] || gm !== exp_m[k]) begin
        n_fail++;
        $display("FAIL bp_issue%0d: ok=%0d bb=%0d mask=%h, required bb=%0d mask=%h", k, ok, gb, gm, exp_bb[k], exp_m[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] gb; logic [W-1:0] gm; bit ok;
    bit seen;
    issue_ready = 1'b1;
    send(5'd4, 64'h7);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rf_read_en;
    end
    @(negedge clk);
    n_tests++;
    if (!seen || issue_valid !== 1'b0 || rf_read_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_reach_wait: seen=%0d v=%b re=%b, required 1/0/0", seen, issue_valid, rf_read_en);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({issue_valid, rf_read_en, rf_write_en, done} !== 4'b0 || issue_bb !== 5'd0 || issue_mask !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: v=%b re=%b we=%b done=%b bb=%0d mask=%h, required all 0",
               issue_valid, rf_read_en, rf_write_en, done, issue_bb, issue_mask);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || issue_bb !== 5'd0 || issue_mask !== all1) begin
      n_fail++; $display("FAIL rst_mid_reissue: v=%b bb=%0d mask=%h, required 1/0/all-ones", issue_valid, issue_bb, issue_mask);
    end
    get_issue(gb, gm, ok);
    repeat (6) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_discard: done=%b v=%b bb=%0d, required 1/0", done, issue_valid, issue_bb);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pend_m [BBS];
    logic [W-1:0] ever_m [BBS];
    logic [W-1:0] left;
    logic         prev_v;
    logic [4:0]   prev_bb;
    logic [W-1:0] prev_m;
    bit           hold;
    logic [4:0]   hold_bb;
    logic [W-1:0] hold_m;
    bit           drained;
    for (int i = 0; i < BBS; i++) begin
      pend_m[i] = '0;
      ever_m[i] = '0;
    end
    pend_m[0] = all1;
    ever_m[0] = all1;
    prev_v = 1'b0; prev_bb = '0; prev_m = '0;
    hold = 1'b0; hold_bb = '0; hold_m = '0;
    drained = 1'b0;
    rst = 1'b0; upd_valid = 1'b0; issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3600 && !drained; c++) begin
      @(negedge clk);
      n_tests++;
      if (rf_write_en !== prev_v || (prev_v && (rf_write_reg !== prev_bb || rf_write_data !== prev_m))) begin
        n_fail++;
        $display("FAIL rnd_write: we=%b reg=%0d data=%h, required %b/%0d/%h",
                 rf_write_en, rf_write_reg, rf_write_data, prev_v, prev_bb, prev_m);
      end
      if (hold) begin
        n_tests++;
        if (issue_valid !== 1'b1 || issue_bb !== hold_bb || issue_mask !== hold_m) begin
          n_fail++;
          $display("FAIL rnd_hold: v=%b bb=%0d mask=%h, required 1/%0d/%h", issue_valid, issue_bb, issue_mask, hold_bb, hold_m);
        end
      end
      issue_ready = (c >= 3000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (issue_valid && issue_ready) begin
        n_tests++;
        if (issue_mask == '0 || (issue_mask & ~ever_m[issue_bb]) != '0) begin
          n_fail++;
          $display("FAIL rnd_phantom: bb=%0d mask=%h, required nonzero subset of %h", issue_bb, issue_mask, ever_m[issue_bb]);
        end
        pend_m[issue_bb] = pend_m[issue_bb] & ~issue_mask;
      end
      hold    = issue_valid && !issue_ready;
      hold_bb = issue_bb;
      hold_m  = issue_mask;
      if (c < 3000) begin
        upd_valid = ($urandom_range(0, 3) == 0);
        upd_bb    = 5'($urandom_range(0, BBS - 1));
        upd_mask  = ($urandom_range(0, 4) == 0) ? '0 : ({$urandom, $urandom} & {$urandom, $urandom});
      end else begin
        upd_valid = 1'b0;
        drained   = (c > 3003) && done;
      end
      if (upd_valid) begin
        pend_m[upd_bb] = pend_m[upd_bb] | upd_mask;
        ever_m[upd_bb] = ever_m[upd_bb] | upd_mask;
      end
      prev_v  = upd_valid && (upd_mask != '0);
      prev_bb = upd_bb;
      prev_m  = upd_mask;
    end
    n_tests++;
    if (!drained) begin
      n_fail++; $display("FAIL rnd_drain: done=%b after drain window, required 1", done);
    end
    left = '0;
    for (int i = 0; i < BBS; i++) left = left | pend_m[i];
    n_tests++;
    if (left !== '0) begin
      n_fail++; $display("FAIL rnd_lost_threads: undelivered threads %h, required 0", left);
    end
  endtask

  initial begin
    all1 = '1;
    test_reset();
    test_order();
    test_merge();
    test_conflict();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bb_frontier_sched.md
# bb_frontier_sched

- Sequences the 32-row basic-block thread-mask register file.
- Accepts thread-mask updates from the CVU and forwards them to the register file's OR-write port.
- Tracks which rows are non-empty and always picks the lowest-indexed pending basic block (thread-frontier order). It reads that row, which clears it in the file, and hands the block index and mask to the warp front-end over a valid/ready handshake.
- Sits between the CVU, the register file and the fetch stage. It is the only master of the register file's read and write ports.

## Interface
Parameters:
- BBS, 32, number of basic-block rows (≤32; block index is 5 bits)
- W, 64, thread-mask width

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, asynchronous, active-low
- upd_valid  in  1  CVU update strobe; always accepted, no ready
- upd_bb  in  5  target basic block
- upd_mask  in  W  threads to add to upd_bb
- rf_write_en  out  1  register-file write enable (OR-write)
- rf_write_reg  out  5  register-file write row
- rf_write_data  out  W  register-file write data
- rf_read_en  out  1  register-file read enable (read-and-clear)
- rf_read_reg  out  5  register-file read row
- rf_read_data  in  W  register-file read data, valid the cycle after rf_read_en
- issue_valid  out  1  issued block available
- issue_ready  in  1  front-end accepts the issued block
- issue_bb  out  5  issued block index
- issue_mask  out  W  issued thread mask
- done  out  1  no pending work anywhere

## Operation

Write stage:
- upd_valid with upd_mask ≠ 0 is registered into a one-entry write register (wr_valid, wr_bb, wr_mask).
- rf_write_en = wr_valid; rf_write_reg = wr_bb; rf_write_data = wr_mask.
- An update with upd_mask = 0 is dropped and sets nothing.
- When wr_valid is set, pending[wr_bb] is set at the same edge that the write commits.

Pending bitmap:
- pending[BBS-1:0], reset value 1 (only bit 0 set), matching row 0 holding all ones after reset.
- The register file must be reset by the same reset event.
- A bit is cleared at the edge where its read commits.
- If a set and a clear hit the same bit on the same edge, the set wins.

FSM states:
- SELECT: if pending ≠ 0, latch sel_bb = lowest set index and go to READ; otherwise stay.
- READ: rf_read_reg = sel_bb; rf_read_en = !(wr_valid && wr_bb == sel_bb).
  - When rf_read_en = 1: clear pending[sel_bb] and go to WAIT.
  - When rf_read_en = 0: stay in READ. This conflict stall ensures an OR-write and a read-clear never hit the same row on the same edge, so no threads are lost.
- WAIT: capture issue_mask <= rf_read_data and issue_bb <= sel_bb, then go to ISSUE.
- ISSUE: issue_valid = 1. issue_bb and issue_mask stay stable until issue_valid && issue_ready, then go to SELECT.

Other rules:
- rf_read_en and issue_valid are decoded from registered state and the write register only; there is no combinational path from inputs.
- Updates are accepted in every state. An update to a block already read (in WAIT or ISSUE) re-sets its pending bit, and the block is reissued later.
- done = (state == SELECT) && pending == 0 && !wr_valid.

Reset (rst low, at any time, including mid-handshake):
- state = SELECT; pending = 1; wr_valid = 0; sel_bb = 0; issue_bb = 0; issue_mask = 0.
- All outputs go to 0 immediately, except done, which is 0 because pending ≠ 0.
- Any in-flight block is discarded.

## Timing
- Update to register-file write: 1 cycle. Update to pending bit visible: 2 edges.
- Pending bit to issue_valid: 3 cycles minimum (SELECT → READ → WAIT → ISSUE), plus 1 cycle per conflict stall.
- Throughput: one block per 4 cycles when issue_ready is held high.
- After reset release: issue_valid rises on the 3rd rising edge, with issue_bb = 0 and issue_mask = all ones.
- Handshake: issue_valid never drops without issue_ready. A block transfers on any edge where valid && ready are both high.

## Test plan
1. Release reset, issue_ready = 1, no updates → issue_bb = 0 and issue_mask = 0xFFFF_FFFF_FFFF_FFFF at cycle 3; after that, done = 1 with no further issue_valid.
2. While block 0 is in ISSUE, send updates bb5/0xF then bb2/0xF0 → issue order is bb2/0xF0, then bb5/0xF; then done = 1.
3. Send updates bb3/0x1 and bb3/0x2 on consecutive cycles before selection → a single issue of bb3 with mask 0x3.
4. Send update bb7/0x100 arriving so that wr_bb = 7 while in READ with sel_bb = 7 → rf_read_en held low for 1 cycle, and the issued mask includes 0x100.
5. Hold issue_ready = 0 for 10 cycles while in ISSUE and send updates → issue_valid, issue_bb and issue_mask stay stable; the updates still reach the register file and set pending.
6. Assert rst low during WAIT → outputs clear immediately; after release, bb0 is issued again at cycle 3.
